// File: rtl/text_ram_arbiter.sv
// Text RAM arbiter: display slot at phase 6, host req/ack port elsewhere.
// Define TEXT_ARB_CLEAR_EN to build the RAM clear engine.
module text_ram_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [8:0]        hpos,
  input  logic [8:0]        vpos,
  input  logic              display_on,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic [DATA_W-1:0] char_code,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic              clear_start,
  output logic              clear_busy
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    ACK
  } host_st_t;

  host_st_t          st;
  logic              rd_pend;
  logic [2:0]        phase;
  logic              disp_slot;
  logic [4:0]        disp_col;
  logic [ADDR_W-1:0] disp_addr;
  logic              busy;
  logic              clr_wr;
  logic [ADDR_W-1:0] clr_addr;
  logic              host_issue;

  assign phase     = hpos[2:0];
  assign disp_slot = (phase == 3'd6);
  assign disp_col  = hpos[7:3] + 5'd1;
  assign disp_addr = {vpos[7:3], disp_col};

`ifdef TEXT_ARB_CLEAR_EN
  logic [ADDR_W-1:0] clr_cnt;

  assign clr_wr   = reset && busy && !disp_slot;
  assign clr_addr = clr_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy    <= 1'b0;
      clr_cnt <= '0;
    end else if (busy) begin
      if (clr_wr) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (&clr_cnt) busy <= 1'b0;
      end
    end else if (clear_start && st == IDLE) begin
      busy    <= 1'b1;
      clr_cnt <= '0;
    end
  end

  logic unused_clr;
  assign unused_clr = 1'b0;
`else
  assign busy     = 1'b0;
  assign clr_wr   = 1'b0;
  assign clr_addr = '0;

  logic unused_clr;
  assign unused_clr = clear_start;
`endif

  assign clear_busy = busy;

  // Host may only start in a free slot while no clear is running.
  assign host_issue = reset && st == IDLE && host_req
                   && !disp_slot && !busy;

  always_comb begin
    ram_addr = disp_addr;
    ram_din  = '0;
    ram_we   = 1'b0;
    unique case (1'b1)
      clr_wr: begin
        ram_addr = clr_addr;
        ram_din  = CLEAR_VALUE;
        ram_we   = 1'b1;
      end
      host_issue: begin
        ram_addr = host_addr;
        if (host_we) begin
          ram_din = host_wdata;
          ram_we  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st         <= IDLE;
      rd_pend    <= 1'b0;
      host_ack   <= 1'b0;
      host_rdata <= '0;
    end else begin
      host_ack <= 1'b0;
      unique case (st)
        IDLE: begin
          if (host_issue) begin
            st      <= DATA;
            rd_pend <= !host_we;
          end
        end
        DATA: begin
          if (rd_pend) host_rdata <= ram_dout;
          host_ack <= 1'b1;
          st       <= ACK;
        end
        ACK:     st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      char_code <= '0;
    end else if (phase == 3'd7) begin
      char_code <= ram_dout;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{display_on, hpos[8], vpos[8],
                       vpos[2:0], unused_clr};

endmodule

// File: tb/tb_text_ram_arbiter.sv
// Bench for text_ram_arbiter: RAM model, beam driver, scenario tasks.
// Clear checks follow TEXT_ARB_CLEAR_EN as the RTL build does.
module tb_text_ram_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] hpos, vpos;
  logic       display_on;
  logic       host_req, host_we;
  logic [9:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_ack;
  logic [7:0] host_rdata, char_code;
  logic [9:0] ram_addr;
  logic [7:0] ram_din, ram_dout;
  logic       ram_we;
  logic       clear_start, clear_busy;

  logic [7:0] mem [1024];
  logic [7:0] ref_mem [1024];
  logic       bk_we;
  logic [9:0] bk_addr;
  logic [7:0] bk_din;

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  text_ram_arbiter dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
    .display_on(display_on), .host_req(host_req),
    .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack),
    .host_rdata(host_rdata), .char_code(char_code),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_dout(ram_dout), .clear_start(clear_start),
    .clear_busy(clear_busy)
  );

  // ram_sync stand-in with a backdoor port for preloading.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    else if (bk_we) mem[bk_addr] <= bk_din;
    ram_dout <= mem[ram_addr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] pat(int a);
    return 8'((a * 37 + 11) % 256);
  endfunction

  function automatic int disp_of(logic [8:0] h, logic [8:0] v);
    int row, col;
    row = (int'(v) / 8) % 32;
    col = (int'(h) / 8 + 1) % 32;
    return row * 32 + col;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (hpos == 9'd799) begin
      hpos = 9'd0;
      vpos = (vpos == 9'd524) ? 9'd0 : vpos + 9'd1;
    end else begin
      hpos = hpos + 9'd1;
    end
    display_on = (hpos < 9'd640) && (vpos < 9'd480);
  endtask

  task automatic bk_fill(int lo, int hi, logic [7:0] x);
    for (int a = lo; a <= hi; a++) begin
      tick();
      bk_we = 1'b1;
      bk_addr = 10'(a);
      bk_din = pat(a) ^ x;
      ref_mem[a] = pat(a) ^ x;
    end
    tick();
    bk_we = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    hpos = 9'd300;
    vpos = 9'd100;
    host_req = 1'b1;
    host_we = 1'b1;
    host_addr = 10'h005;
    host_wdata = 8'hFF;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      n_run += 4;
      if (char_code !== 8'h00) begin
        n_fail++;
        $display("FAIL rst_char: got %h want 00", char_code);
      end
      if (host_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_ack: got %b want 0", host_ack);
      end
      if (ram_we !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_we: got %b want 0", ram_we);
      end
      if (clear_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_busy: got %b want 0", clear_busy);
      end
    end
    tick();
    reset = 1'b1;
    host_req = 1'b0;
    tick();
    @(negedge clk);
    n_run++;
    if (mem[5] !== ref_mem[5]) begin
      n_fail++;
      $display("FAIL rst_nowrite: got %h want %h", mem[5], ref_mem[5]);
    end
  endtask

  task automatic test_display_fetch();
    tick();
    bk_we = 1'b1;
    bk_addr = 10'h045;
    bk_din = 8'h07;
    ref_mem[10'h045] = 8'h07;
    tick();
    bk_we = 1'b0;
    hpos = 9'd38;
    vpos = 9'd17;
    @(negedge clk);
    n_run += 2;
    if (ram_addr !== 10'h045) begin
      n_fail++;
      $display("FAIL disp_addr: got %h want 045", ram_addr);
    end
    if (ram_we !== 1'b0) begin
      n_fail++;
      $display("FAIL disp_we: got %b want 0", ram_we);
    end
    tick();
    for (int p = 0; p < 8; p++) begin
      tick();
      @(negedge clk);
      n_run++;
      if (char_code !== 8'h07) begin
        n_fail++;
        $display("FAIL disp_char ph%0d: got %h want 07", p, char_code);
      end
    end
  endtask

  task automatic test_collision_write();
    logic [7:0] exp_disp;
    int da;
    tick();
    hpos = 9'd30;
    vpos = 9'd40;
    host_req = 1'b1;
    host_we = 1'b1;
    host_addr = 10'h3FF;
    host_wdata = 8'hA5;
    da = disp_of(hpos, vpos);
    exp_disp = ref_mem[da];
    @(negedge clk);
    n_run += 2;
    if (ram_we !== 1'b0) begin
      n_fail++;
      $display("FAIL col_p6_we: got %b want 0", ram_we);
    end
    if (ram_addr !== 10'(da)) begin
      n_fail++;
      $display("FAIL col_p6_addr: got %h want %h", ram_addr, 10'(da));
    end
    tick();
    @(negedge clk);
    ref_mem[10'h3FF] = 8'hA5;
    n_run += 3;
    if (ram_we !== 1'b1) begin
      n_fail++;
      $display("FAIL col_p7_we: got %b want 1", ram_we);
    end
    if (ram_addr !== 10'h3FF) begin
      n_fail++;
      $display("FAIL col_p7_addr: got %h want 3ff", ram_addr);
    end
    if (ram_din !== 8'hA5) begin
      n_fail++;
      $display("FAIL col_p7_din: got %h want a5", ram_din);
    end
    tick();
    @(negedge clk);
    n_run += 2;
    if (host_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL col_p0_ack: got %b want 0", host_ack);
    end
    if (char_code !== exp_disp) begin
      n_fail++;
      $display("FAIL col_disp: got %h want %h", char_code, exp_disp);
    end
    tick();
    @(negedge clk);
    n_run++;
    if (host_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL col_p1_ack: got %b want 1", host_ack);
    end
    tick();
    host_req = 1'b0;
    @(negedge clk);
    n_run += 2;
    if (host_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL col_ack_fall: got %b want 0", host_ack);
    end
    if (mem[10'h3FF] !== 8'hA5) begin
      n_fail++;
      $display("FAIL col_ram: got %h want a5", mem[10'h3FF]);
    end
  endtask

  task automatic test_host_read();
    tick();
    hpos = 9'd82;
    vpos = 9'd60;
    host_req = 1'b1;
    host_we = 1'b0;
    host_addr = 10'h3FF;
    @(negedge clk);
    n_run += 2;
    if (ram_addr !== 10'h3FF) begin
      n_fail++;
      $display("FAIL rd_addr: got %h want 3ff", ram_addr);
    end
    if (ram_we !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_we: got %b want 0", ram_we);
    end
    tick();
    @(negedge clk);
    n_run++;
    if (host_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_early_ack: got %b want 0", host_ack);
    end
    tick();
    @(negedge clk);
    n_run += 2;
    if (host_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_ack: got %b want 1", host_ack);
    end
    if (host_rdata !== 8'hA5) begin
      n_fail++;
      $display("FAIL rd_data: got %h want a5", host_rdata);
    end
    tick();
    host_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_run += 2;
      if (host_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL rd_ack_fall: got %b want 0", host_ack);
      end
      if (host_rdata !== 8'hA5) begin
        n_fail++;
        $display("FAIL rd_hold: got %h want a5", host_rdata);
      end
      tick();
    end
  endtask

  task automatic test_random_host();
    int exp_issue, exp_ack, gap, da;
    bit active, we_t, snap_ok, cur_ok, rd_ok, exp_we;
    logic [9:0] a_t;
    logic [7:0] d_t, snap, cur, rd_exp, last_rd;
    active = 1'b0;
    gap = 2;
    snap_ok = 1'b0;
    cur_ok = 1'b0;
    rd_ok = 1'b0;
    we_t = 1'b0;
    a_t = '0;
    d_t = '0;
    snap = '0;
    cur = '0;
    rd_exp = '0;
    last_rd = '0;
    exp_issue = -10;
    exp_ack = -10;
    tick();
    host_req = 1'b0;
    hpos = 9'($urandom_range(0, 799));
    vpos = 9'($urandom_range(0, 524));
    for (int k = 0; k < 3000; k++) begin
      tick();
      if (!active) begin
        if (gap == 0) begin
          active = 1'b1;
          we_t = 1'($urandom_range(0, 1));
          a_t = 10'($urandom);
          d_t = 8'($urandom);
          host_req = 1'b1;
          host_we = we_t;
          host_addr = a_t;
          host_wdata = d_t;
          exp_issue = (hpos[2:0] == 3'd6) ? cyc + 1 : cyc;
          exp_ack = exp_issue + 2;
        end else begin
          host_req = 1'b0;
          gap--;
        end
      end
      @(negedge clk);
      if (cyc == exp_issue) begin
        rd_exp = ref_mem[a_t];
        if (we_t) ref_mem[a_t] = d_t;
        n_run++;
        if (ram_addr !== a_t) begin
          n_fail++;
          $display("FAIL rnd_addr c%0d: got %h want %h", cyc, ram_addr, a_t);
        end
      end
      exp_we = (cyc == exp_issue) && we_t;
      n_run++;
      if (ram_we !== exp_we) begin
        n_fail++;
        $display("FAIL rnd_we c%0d: got %b want %b", cyc, ram_we, exp_we);
      end
      if (hpos[2:0] == 3'd6) begin
        da = disp_of(hpos, vpos);
        n_run++;
        if (ram_addr !== 10'(da)) begin
          n_fail++;
          $display("FAIL rnd_disp c%0d: got %h want %h", cyc, ram_addr, 10'(da));
        end
      end
      n_run++;
      if (host_ack !== (cyc == exp_ack)) begin
        n_fail++;
        $display("FAIL rnd_ack c%0d: got %b want %b", cyc, host_ack, cyc == exp_ack);
      end
      if (cyc == exp_ack) begin
        if (!we_t) begin
          rd_ok = 1'b1;
          last_rd = rd_exp;
        end
        active = 1'b0;
        gap = $urandom_range(0, 4);
      end
      if (rd_ok) begin
        n_run++;
        if (host_rdata !== last_rd) begin
          n_fail++;
          $display("FAIL rnd_rdata c%0d: got %h want %h", cyc, host_rdata, last_rd);
        end
      end
      if (hpos[2:0] == 3'd0 && snap_ok) begin
        cur = snap;
        cur_ok = 1'b1;
      end
      if (cur_ok) begin
        n_run++;
        if (char_code !== cur) begin
          n_fail++;
          $display("FAIL rnd_char c%0d: got %h want %h", cyc, char_code, cur);
        end
      end
      if (hpos[2:0] == 3'd6) begin
        snap = ref_mem[disp_of(hpos, vpos)];
        snap_ok = 1'b1;
      end
    end
    tick();
    host_req = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_clear();
`ifdef TEXT_ARB_CLEAR_EN
    int busy_cycles, drop_cyc, ack_cyc, p0, drop_ph;
    int n_wr, c_model, p, nz;
    tick();
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    host_req = 1'b1;
    host_we = 1'b0;
    host_addr = 10'h123;
    busy_cycles = 0;
    drop_cyc = -1;
    drop_ph = 0;
    ack_cyc = -1;
    p0 = -1;
    for (int k = 0; k < 1400 && ack_cyc < 0; k++) begin
      @(negedge clk);
      if (clear_busy) begin
        if (busy_cycles == 0) p0 = int'(hpos[2:0]);
        busy_cycles++;
      end else if (busy_cycles > 0 && drop_cyc < 0) begin
        drop_cyc = cyc;
        drop_ph = int'(hpos[2:0]);
      end
      if (host_ack) ack_cyc = cyc;
      tick();
    end
    host_req = 1'b0;
    n_wr = 0;
    c_model = 0;
    p = (p0 < 0) ? 0 : p0;
    while (n_wr < 1024) begin
      if (p != 6) n_wr++;
      c_model++;
      p = (p + 1) % 8;
    end
    n_run += 4;
    if (busy_cycles != c_model || p0 < 0) begin
      n_fail++;
      $display("FAIL clr_len: got %0d want %0d", busy_cycles, c_model);
    end
    if (busy_cycles > 1172) begin
      n_fail++;
      $display("FAIL clr_max: got %0d want <=1172", busy_cycles);
    end
    if (drop_cyc < 0 || ack_cyc != drop_cyc + ((drop_ph == 6) ? 3 : 2)) begin
      n_fail++;
      $display("FAIL clr_host_ack: got c%0d want after drop c%0d", ack_cyc, drop_cyc);
    end
    if (host_rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL clr_rdata: got %h want 00", host_rdata);
    end
    repeat (3) tick();
    nz = 0;
    for (int a = 0; a < 1024; a++) begin
      if (mem[a] !== 8'h00) nz++;
      ref_mem[a] = 8'h00;
    end
    n_run++;
    if (nz != 0) begin
      n_fail++;
      $display("FAIL clr_fill: got %0d dirty cells want 0", nz);
    end
`else
    int diff;
    tick();
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      n_run += 2;
      if (clear_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL clr_off_busy: got %b want 0", clear_busy);
      end
      if (ram_we !== 1'b0) begin
        n_fail++;
        $display("FAIL clr_off_we: got %b want 0", ram_we);
      end
      tick();
    end
    diff = 0;
    for (int a = 0; a < 1024; a++)
      if (mem[a] !== ref_mem[a]) diff++;
    n_run++;
    if (diff != 0) begin
      n_fail++;
      $display("FAIL clr_off_ram: got %0d changed cells want 0", diff);
    end
`endif
  endtask

  task automatic test_reset_midop();
    bit got;
    tick();
    hpos = 9'd201;
    vpos = 9'd33;
    host_req = 1'b1;
    host_we = 1'b1;
    host_addr = 10'h010;
    host_wdata = 8'h3C;
    ref_mem[10'h010] = 8'h3C;
    tick();
    reset = 1'b0;
    host_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 3) reset = 1'b1;
      @(negedge clk);
      n_run++;
      if (host_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_host_ack: got %b want 0", host_ack);
      end
    end
    tick();
    host_req = 1'b1;
    host_we = 1'b0;
    host_addr = 10'h010;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (host_ack) got = 1'b1;
      tick();
    end
    host_req = 1'b0;
    n_run += 2;
    if (!got) begin
      n_fail++;
      $display("FAIL mid_fresh_ack: got none want ack");
    end
    if (host_rdata !== 8'h3C) begin
      n_fail++;
      $display("FAIL mid_fresh_data: got %h want 3c", host_rdata);
    end
`ifdef TEXT_ARB_CLEAR_EN
    begin
      bit hit;
      int diff;
      bk_fill(512, 1023, 8'h5A);
      for (int a = 0; a < 512; a++) ref_mem[a] = 8'h00;
      tick();
      clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      hit = 1'b0;
      for (int k = 0; k < 800 && !hit; k++) begin
        @(negedge clk);
        if (ram_we && ram_addr == 10'h200) begin
          reset = 1'b0;
          hit = 1'b1;
        end else begin
          tick();
        end
      end
      n_run++;
      if (!hit) begin
        n_fail++;
        $display("FAIL mid_clr_reach: got none want write to 200");
      end
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        n_run += 2;
        if (clear_busy !== 1'b0) begin
          n_fail++;
          $display("FAIL mid_clr_busy: got %b want 0", clear_busy);
        end
        if (ram_we !== 1'b0) begin
          n_fail++;
          $display("FAIL mid_clr_we: got %b want 0", ram_we);
        end
        tick();
      end
      diff = 0;
      for (int a = 0; a < 1024; a++)
        if (mem[a] !== ref_mem[a]) diff++;
      n_run++;
      if (diff != 0) begin
        n_fail++;
        $display("FAIL mid_clr_ram: got %0d wrong cells want 0", diff);
      end
    end
`endif
  endtask

  initial begin
    reset = 1'b0;
    hpos = 9'd0;
    vpos = 9'd0;
    display_on = 1'b1;
    host_req = 1'b0;
    host_we = 1'b0;
    host_addr = '0;
    host_wdata = '0;
    clear_start = 1'b0;
    bk_we = 1'b0;
    bk_addr = '0;
    bk_din = '0;
    bk_fill(0, 1023, 8'h00);
    tick();
    reset = 1'b1;
    repeat (20) tick();

    test_reset();
    test_display_fetch();
    test_collision_write();
    test_host_read();
    test_random_host();
    test_clear();
    test_reset_midop();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
